// File: rtl/vote_pkg.sv
// vote_pkg: shared widths, frame constants and FSM state types for the vote tally path
package vote_pkg;
  localparam int NUM_CANDIDATES = 4;
  localparam int VOTE_W = 8;
  localparam int FRAME_BYTES = 6;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} tx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_SEND, F_FINISH} frame_state_e;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte; a load in the last stop-bit cycle chains bytes gap-free
module uart_tx_byte
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  tx_state_e r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_wrap;
  logic w_shift;
  assign w_wrap = r_timer == TW'(CLKS_PER_BIT - 1);
  assign w_shift = w_wrap && r_state == DATA_BITS;
  always_comb begin
    w_next = r_state;
    if (load) w_next = START_BIT;
    else if (w_wrap)
      w_next = r_state == START_BIT ? DATA_BITS :
               r_state == DATA_BITS ? (r_bit == 3'd7 ? STOP_BIT : DATA_BITS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_timer <= (load || w_wrap || r_state == IDLE) ? '0 : r_timer + 1'b1;
      r_bit   <= load ? 3'd0 : w_shift ? r_bit + 3'd1 : r_bit;
      r_shift <= load ? data : w_shift ? {1'b0, r_shift[7:1]} : r_shift;
    end
  end
  assign tx = r_state == START_BIT ? 1'b0 : r_state == DATA_BITS ? r_shift[0] : 1'b1;
  assign byte_done = r_state == STOP_BIT && w_wrap;
endmodule

// File: rtl/vote_result_tx.sv
// vote_result_tx: snapshots the four candidate counts and sends header, counts and checksum as one UART burst
module vote_result_tx
  import vote_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEADER_BYTE  = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] cand1_vote_recvd,
  input  logic [7:0] cand2_vote_recvd,
  input  logic [7:0] cand3_vote_recvd,
  input  logic [7:0] cand4_vote_recvd,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  frame_state_e r_state, w_next;
  logic [VOTE_W-1:0] r_c1, r_c2, r_c3, r_c4, r_cksum;
  logic [2:0] r_byte_idx, w_sel;
  logic [9:0] w_sum;
  logic [7:0] w_byte;
  logic w_accept, w_byte_done, w_last, w_load;
  assign w_accept = r_state == F_IDLE && start && mode;
  assign w_last = r_byte_idx == 3'(FRAME_BYTES - 1);
  assign w_load = w_accept || (r_state == F_SEND && w_byte_done && !w_last);
  assign w_sum = 10'(cand1_vote_recvd) + 10'(cand2_vote_recvd) + 10'(cand3_vote_recvd) + 10'(cand4_vote_recvd);
  // The next byte is chosen combinationally so it loads on the same edge the previous stop bit ends.
  assign w_sel = w_accept ? 3'd0 : r_byte_idx + 3'd1;
  always_comb begin
    w_byte = w_sel == 3'd0 ? HEADER_BYTE : w_sel == 3'd1 ? r_c1 : w_sel == 3'd2 ? r_c2 :
             w_sel == 3'd3 ? r_c3 : w_sel == 3'd4 ? r_c4 : r_cksum;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == F_IDLE) w_next = w_accept ? F_SEND : F_IDLE;
    else if (r_state == F_SEND) w_next = (w_byte_done && w_last) ? F_FINISH : F_SEND;
    else w_next = F_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= F_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
      r_c3 <= '0;
      r_c4 <= '0;
      r_cksum <= '0;
    end else if (w_accept) begin
      r_byte_idx <= '0;
      r_c1 <= cand1_vote_recvd;
      r_c2 <= cand2_vote_recvd;
      r_c3 <= cand3_vote_recvd;
      r_c4 <= cand4_vote_recvd;
      r_cksum <= w_sum[7:0];
    end else if (w_load) begin
      r_byte_idx <= w_sel;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .reset(reset),
    .load(w_load),
    .data(w_byte),
    .tx(tx),
    .byte_done(w_byte_done)
  );
  assign busy = r_state == F_SEND;
  assign done = r_state == F_FINISH;
endmodule

// File: tb/tb_vote_result_tx.sv
// tb_vote_result_tx: randomized frames decoded by a mid-bit UART monitor and checked against a byte-list model
module tb_vote_result_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, reset = 1'b1, mode = 1'b0, start = 1'b0;
  logic [7:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic tx, busy, done;
  int total = 0, bad = 0;
  int n_done = 0, n_busy = 0, n_low = 0, n_ferr = 0;
  logic [7:0] rx_q[$];

  vote_result_tx #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .start(start),
    .cand1_vote_recvd(c1),
    .cand2_vote_recvd(c2),
    .cand3_vote_recvd(c3),
    .cand4_vote_recvd(c4),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (busy === 1'b1) n_busy++;
    if (tx === 1'b0) n_low++;
  end

  // Hunts for a falling edge, then samples each bit in its middle cycle.
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) continue;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx === 1'b1) rx_q.push_back(b);
        else n_ferr++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++; if (n_low != 0) begin bad++; $display("FAIL idle_tx: low samples %0d want 0", n_low); end
    total++; if (n_busy != 0 || n_done != 0) begin bad++; $display("FAIL idle_busy: busy %0d done %0d want 0 0", n_busy, n_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input bit perturb, input bit restart);
    logic [7:0] e[6];
    int base, d0, b0, f0, d1, l1;
    e[0] = 8'hA5; e[1] = a; e[2] = b; e[3] = c; e[4] = d;
    e[5] = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
    c1 = a; c2 = b; c3 = c; c4 = d; mode = 1'b1;
    base = rx_q.size(); d0 = n_done; b0 = n_busy; f0 = n_ferr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (perturb) begin c1 = 8'hFF; c2 = 8'hFF; c3 = 8'hFF; c4 = 8'hFF; mode = 1'b0; end
    @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL %s_latency: tx %b want 0", nm, tx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise: busy %b want 1", nm, busy); end
    for (int i = 0; i < 400 && n_done == d0; i++) begin
      @(negedge clk); #1;
      if (restart) start = (i == 100);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_done - d0 != 1) begin bad++; $display("FAIL %s_done: pulses %0d want 1", nm, n_done - d0); end
    total++; if (n_busy - b0 != 60 * CPB) begin bad++; $display("FAIL %s_busy_len: %0d want %0d", nm, n_busy - b0, 60 * CPB); end
    total++; if (rx_q.size() - base != 6) begin bad++; $display("FAIL %s_nbytes: %0d want 6", nm, rx_q.size() - base); end
    total++; if (n_ferr != f0) begin bad++; $display("FAIL %s_stopbit: errors %0d want 0", nm, n_ferr - f0); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (base + k >= rx_q.size() || rx_q[base + k] !== e[k]) begin
        bad++;
        $display("FAIL %s_byte%0d: got %h want %h", nm, k, (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx, e[k]);
      end
    end
    if (restart) begin
      d1 = n_done; l1 = n_low;
      repeat (300) @(negedge clk);
      #1;
      total++; if (n_done != d1 || n_low != l1) begin bad++; $display("FAIL %s_no_queue: extra done %0d low %0d want 0 0", nm, n_done - d1, n_low - l1); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    test_frame("basic", 8'd3, 8'd5, 8'd7, 8'd9, 1'b0, 1'b0);
  endtask

  task automatic test_checksum();
    test_frame("wrap1", 8'd200, 8'd100, 8'd0, 8'd0, 1'b0, 1'b0);
    test_frame("wrap2", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
  endtask

  task automatic test_gating();
    int l0, b0;
    l0 = n_low; b0 = n_busy;
    mode = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    total++; if (n_low != l0) begin bad++; $display("FAIL mode0_tx: low samples %0d want 0", n_low - l0); end
    total++; if (n_busy != b0) begin bad++; $display("FAIL mode0_busy: busy samples %0d want 0", n_busy - b0); end
    @(posedge clk); #1;
    test_frame("busy_start", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
  endtask

  task automatic test_snapshot();
    test_frame("snapshot", 8'($urandom_range(0, 254)), 8'd17, 8'($urandom), 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d0;
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midreset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    reset = 1'b0;
    d0 = n_done;
    repeat (300) @(negedge clk);
    #1;
    total++; if (n_done != d0) begin bad++; $display("FAIL midreset_done: pulses %0d want 0", n_done - d0); end
    @(posedge clk); #1;
    test_frame("after_reset", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[6];
    int base, d0, b0, d1;
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    e[0] = 8'hA5; e[1] = c1; e[2] = c2; e[3] = c3; e[4] = c4;
    e[5] = 8'((int'(c1) + int'(c2) + int'(c3) + int'(c4)) % 256);
    base = rx_q.size(); d0 = n_done; b0 = n_busy;
    mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 800 && n_done - d0 < 2; i++) begin
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_done - d0 != 2) begin bad++; $display("FAIL b2b_done: pulses %0d want 2", n_done - d0); end
    total++; if (n_busy - b0 != 120 * CPB) begin bad++; $display("FAIL b2b_busy: %0d want %0d", n_busy - b0, 120 * CPB); end
    total++; if (rx_q.size() - base != 12) begin bad++; $display("FAIL b2b_nbytes: %0d want 12", rx_q.size() - base); end
    for (int k = 0; k < 12; k++) begin
      total++;
      if (base + k >= rx_q.size() || rx_q[base + k] !== e[k % 6]) begin
        bad++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx, e[k % 6]);
      end
    end
    d1 = n_done;
    repeat (300) @(negedge clk);
    #1;
    total++; if (n_done != d1) begin bad++; $display("FAIL b2b_stop: extra done %0d want 0", n_done - d1); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++)
      test_frame("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_gating();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
